one_hot_decoder: RTL

- Streaming one-hot to binary decoder. It is the inverse of the team's combinational one-hot encoder.
- Accepts a DATA_SIZE-bit one-hot word over a valid/ready handshake and returns the DATA_WIDTH-bit binary index one cycle later.
- Flags zero-hot and multi-hot words and keeps a saturating error count.
- Sits between select/grant logic (arbiters, LED/segment mux scanners) and downstream binary-index consumers.

---
 rtl/one_hot_pkg.sv | 23 ++
 rtl/one_hot_decoder_if.sv | 44 ++++
 rtl/one_hot_check.sv | 28 ++
 rtl/one_hot_decoder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/one_hot_pkg.sv
// Shared constants, skid-state type and one-hot helpers
// for the one-hot encoder/decoder family.
package one_hot_pkg;

    localparam int DEF_DATA_WIDTH    = 3;
    localparam int DEF_DATA_SIZE     = 1 << DEF_DATA_WIDTH;
    localparam int DEF_ERR_CNT_WIDTH = 8;
    localparam int MAX_SIZE          = 256;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    function automatic logic onehot_popcount_le1(
        input logic [MAX_SIZE-1:0] w
    );
        return (w & (w - MAX_SIZE'(1))) == '0;
    endfunction

endpackage

// File: rtl/one_hot_decoder_if.sv
// Valid/ready bundle between a one-hot producer and
// the one_hot_decoder plus its error-counter controls.
interface one_hot_decoder_if #(
    parameter int DATA_WIDTH    = 3,
    parameter int ERR_CNT_WIDTH = 8
);

    localparam int DATA_SIZE = 1 << DATA_WIDTH;

    logic [DATA_SIZE-1:0]     i_one_hot;
    logic                     i_valid;
    logic                     o_ready;
    logic [DATA_WIDTH-1:0]    o_val;
    logic                     o_error;
    logic                     o_valid;
    logic                     i_ready;
    logic                     i_err_clr;
    logic [ERR_CNT_WIDTH-1:0] o_err_count;

    modport slave (
        input  i_one_hot,
        input  i_valid,
        output o_ready,
        output o_val,
        output o_error,
        output o_valid,
        input  i_ready,
        input  i_err_clr,
        output o_err_count
    );

    modport master (
        output i_one_hot,
        output i_valid,
        input  o_ready,
        input  o_val,
        input  o_error,
        input  o_valid,
        output i_ready,
        output i_err_clr,
        input  o_err_count
    );

endinterface

// File: rtl/one_hot_check.sv
// Combinational one-hot word check: lowest set index,
// zero-hot and multi-hot flags.
module one_hot_check
    import one_hot_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int DATA_SIZE  = 1 << DATA_WIDTH
) (
    input  logic [DATA_SIZE-1:0]  word,
    output logic [DATA_WIDTH-1:0] index,
    output logic                  is_zero,
    output logic                  is_multi
);

    // Scanning downwards leaves the lowest set bit as the final winner.
    always_comb begin
        index = '0;
        for (int i = DATA_SIZE - 1; i >= 0; i--) begin
            if (word[i]) begin
                index = i[DATA_WIDTH-1:0];
            end
        end
    end

    assign is_zero  = ~|word;
    assign is_multi = !onehot_popcount_le1(MAX_SIZE'(word));

endmodule

// File: rtl/one_hot_decoder.sv
// Streaming one-hot to binary decoder with skid buffer and error count.
// ONE_HOT_DECODER_PRIORITY_EN: multi-hot words decode to lowest set bit.
module one_hot_decoder
    import one_hot_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    one_hot_decoder_if.slave bus
);

    skid_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]    main_val_q, main_val_d;
    logic                     main_err_q, main_err_d;
    logic [DATA_WIDTH-1:0]    skid_val_q, skid_val_d;
    logic                     skid_err_q, skid_err_d;
    logic                     ready_q;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] index;
    logic                  is_zero;
    logic                  is_multi;
    logic [DATA_WIDTH-1:0] dec_val;
    logic                  dec_err;
    logic                  accept;
    logic                  xfer;

    one_hot_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_check (
        .word     (bus.i_one_hot),
        .index    (index),
        .is_zero  (is_zero),
        .is_multi (is_multi)
    );

    assign dec_err = is_zero | is_multi;

`ifdef ONE_HOT_DECODER_PRIORITY_EN
    assign dec_val = is_zero ? '0 : index;
`else
    assign dec_val = dec_err ? '0 : index;
`endif

    assign accept = bus.i_valid && ready_q;
    assign xfer   = (state_q != EMPTY) && bus.i_ready;

    always_comb begin
        state_d    = state_q;
        main_val_d = main_val_q;
        main_err_d = main_err_q;
        skid_val_d = skid_val_q;
        skid_err_d = skid_err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = BUSY;
                    main_val_d = dec_val;
                    main_err_d = dec_err;
                end
            end
            BUSY: begin
                if (accept && !xfer) begin
                    state_d    = FULL;
                    skid_val_d = dec_val;
                    skid_err_d = dec_err;
                end else if (accept) begin
                    main_val_d = dec_val;
                    main_err_d = dec_err;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d    = BUSY;
                    main_val_d = skid_val_q;
                    main_err_d = skid_err_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // A clear in the same cycle as an erroneous accept still counts it.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_err_clr) begin
            cnt_d = ERR_CNT_WIDTH'(accept && dec_err);
        end else if (accept && dec_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= EMPTY;
            main_val_q <= '0;
            main_err_q <= 1'b0;
            skid_val_q <= '0;
            skid_err_q <= 1'b0;
            ready_q    <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_val_q <= main_val_d;
            main_err_q <= main_err_d;
            skid_val_q <= skid_val_d;
            skid_err_q <= skid_err_d;
            ready_q    <= (state_d != FULL);
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_valid     = (state_q != EMPTY);
    assign bus.o_ready     = ready_q;
    assign bus.o_val       = main_val_q;
    assign bus.o_error     = main_err_q;
    assign bus.o_err_count = cnt_q;

endmodule
